midi_note_decoder: RTL and testbench
====================================

Name: midi_note_decoder

Overview:
- Upstream stage of the synth oscillator.
- Parses a raw MIDI byte stream from the UART receiver: status bytes, running status, Note On/Off for one MIDI channel.
- Maintains a monophonic "current note" and drives the oscillator's 7-bit note index (MIDI note − 21, range 0..87) plus gate/velocity for the envelope stage.

Parameters:
- CHANNEL, 4'd0, MIDI channel (0-based) accepted when OMNI=0.
- OMNI, 1'b0, 1 = accept Note On/Off on every channel.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- rx_data  input  8  received MIDI byte
- rx_valid  input  1  one-cycle strobe, rx_data valid; back-to-back strobes allowed
- freq  output  7  note index = MIDI note − 21 (0..87), feeds oscillator freq
- velocity  output  7  velocity of current note
- gate  output  1  1 while a note is held
- note_on_pulse  output  1  one-cycle strobe on accepted Note On
- note_off_pulse  output  1  one-cycle strobe when gate falls

Behaviour:
- Clock and reset: one clock `clk`. `reset` is synchronous and active-high.
- Reset state:
  - freq=0, velocity=0, gate=0, both pulses 0.
  - Running status cleared (invalid).
  - FSM in IDLE.
- Byte classes:
  - Status: bit7=1.
  - Data: bit7=0.
  - Real-time: 0xF8–0xFF. Ignored completely, with no state, FSM or running-status change, even between two data bytes.
  - System common / SysEx: 0xF0–0xF7. Clears running status and returns FSM to IDLE. Following data bytes are discarded until the next channel status.
- Channel status 0x80–0xEF:
  - Latches running status and byte count: 1 for 0xC_/0xD_, 2 otherwise.
  - FSM → WAIT_D1.
  - A new status byte mid-message aborts the partial message.
- FSM states: IDLE, WAIT_D1, WAIT_D2.
  - IDLE + data byte + valid running status: treated as D1 (running status), → WAIT_D2 or completes if 1-byte message.
  - IDLE + data byte + no running status: dropped.
  - WAIT_D1 + data: store D1; → WAIT_D2 if 2-byte message, else complete (discard) → IDLE.
  - WAIT_D2 + data: message complete → IDLE; running status retained.
- Message match:
  - Only 0x8n/0x9n are acted on.
  - n must equal CHANNEL, or OMNI=1.
  - All other complete messages are consumed silently.
- Note range: note must be 21..108. Out-of-range notes are dropped with no output change and no pulse.
- Note On with velocity ≠ 0:
  - freq ← note−21, velocity ← vel, gate ← 1.
  - note_on_pulse=1 for one cycle.
  - Retrigger and legato both pulse note_on (last-note priority).
- Note Off (0x8n, or 0x9n with vel=0):
  - Acts only if gate=1 and note−21 == freq.
  - Then gate ← 0 and note_off_pulse=1 for one cycle.
  - freq and velocity hold their last values.
  - A non-matching note is ignored.
- Latency: outputs and pulses are registered and change on the clock edge after the rx_valid cycle carrying the final data byte, i.e. 1 cycle latency.
- Pulses are never simultaneous; each completes one message at most.
- Reset asserted mid-message: partial message discarded, all outputs return to reset values on that edge.
- rx_valid=0: rx_data ignored.

Test Plan:
- Reset, then bytes 0x90,0x45,0x64 → after last byte +1 cycle: freq=48, velocity=100, gate=1, note_on_pulse high exactly 1 cycle.
- Running status: 0x90,0x3C,0x40 then 0x40,0x50 → second note gives freq=43, velocity=80, second note_on_pulse; then 0x3C,0x00 → ignored (freq≠39); then 0x40,0x00 → gate=0, note_off_pulse 1 cycle, freq stays 43.
- Real-time interleave: 0x90,0xF8,0x45,0xFE,0x7F → freq=48, velocity=127, gate=1; no disruption from 0xF8/0xFE.
- Filtering:
  - CHANNEL=0: 0x91,0x45,0x64 → no change.
  - Out-of-range 0x90,0x14,0x64 and 0x90,0x6D,0x64 → no change.
  - 0xC0,0x05 then 0x45,0x64 → consumed, no note.
  - OMNI=1: the first message → freq=48.
- SysEx and abort:
  - 0x90,0x45,0xF0,0x01,0x02,0xF7,0x45,0x64 → no output change (running status cleared).
  - 0x90,0x45 then reset → all outputs 0; subsequent 0x64 dropped.

Source files
------------

// File: rtl/midi_note_decoder.sv
// MIDI byte-stream parser for one channel (or omni): tracks running status and
// drives a monophonic last-note-priority note index, velocity and gate.
module midi_note_decoder #(
    parameter logic [3:0] CHANNEL = 4'd0,
    parameter logic       OMNI    = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [6:0] freq,
    output logic [6:0] velocity,
    output logic       gate,
    output logic       note_on_pulse,
    output logic       note_off_pulse
);

    typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2} state_t;

    // Snapshot of a just-completed message, valid for the cycle its last byte arrives.
    typedef struct packed {
        logic [7:0] status;
        logic [6:0] d1;
        logic [6:0] d2;
    } msg_t;

    state_t     state;
    logic [7:0] run_status;
    logic       run_valid;
    logic [6:0] d1;

    logic       is_sys, is_chan, is_data;
    logic       two_byte;
    logic       msg_done;
    msg_t       msg;
    logic       chan_ok, is_note, in_range, act;
    logic       do_on, do_off;
    logic [6:0] note_idx;

    // Real-time bytes (F8..FF) match none of these classes, so they fall through untouched.
    assign is_sys  = rx_valid && (rx_data[7:3] == 5'b11110);
    assign is_chan = rx_valid && rx_data[7] && (rx_data[7:4] != 4'hF);
    assign is_data = rx_valid && !rx_data[7];

    // Program change (Cn) and channel pressure (Dn) carry a single data byte.
    assign two_byte = (run_status[7:5] != 3'b110);

    always_comb begin
        msg_done = 1'b0;
        msg      = '0;
        if (is_data && run_valid) begin
            if (state == WAIT_D2) begin
                msg_done = 1'b1;
                msg      = '{status: run_status, d1: d1, d2: rx_data[6:0]};
            end else if (!two_byte) begin
                msg_done = 1'b1;
                msg      = '{status: run_status, d1: rx_data[6:0], d2: 7'd0};
            end
        end
    end

    assign chan_ok  = OMNI || (msg.status[3:0] == CHANNEL);
    assign is_note  = (msg.status[7:5] == 3'b100);
    assign in_range = (msg.d1 >= 7'd21) && (msg.d1 <= 7'd108);
    assign act      = msg_done && is_note && chan_ok && in_range;
    assign note_idx = msg.d1 - 7'd21;
    assign do_on    = act && msg.status[4] && (msg.d2 != 7'd0);
    assign do_off   = act && !do_on && gate && (note_idx == freq);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            run_status     <= 8'd0;
            run_valid      <= 1'b0;
            d1             <= 7'd0;
            freq           <= 7'd0;
            velocity       <= 7'd0;
            gate           <= 1'b0;
            note_on_pulse  <= 1'b0;
            note_off_pulse <= 1'b0;
        end else begin
            note_on_pulse  <= 1'b0;
            note_off_pulse <= 1'b0;

            if (is_sys) begin
                run_valid <= 1'b0;
                state     <= IDLE;
            end else if (is_chan) begin
                run_status <= rx_data;
                run_valid  <= 1'b1;
                state      <= WAIT_D1;
            end else if (is_data && run_valid) begin
                case (state)
                    WAIT_D2: state <= IDLE;
                    default: begin
                        if (two_byte) begin
                            d1    <= rx_data[6:0];
                            state <= WAIT_D2;
                        end else begin
                            state <= IDLE;
                        end
                    end
                endcase
            end

            if (do_on) begin
                freq          <= note_idx;
                velocity      <= msg.d2;
                gate          <= 1'b1;
                note_on_pulse <= 1'b1;
            end else if (do_off) begin
                gate           <= 1'b0;
                note_off_pulse <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_midi_note_decoder.sv
// Directed bench: a channel-0 instance and an omni instance (CHANNEL=3) share one byte stream.
module tb_midi_note_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;

    logic [6:0] freq0, vel0, freq1, vel1;
    logic       gate0, on0, off0, gate1, on1, off1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    midi_note_decoder #(.CHANNEL(4'd0), .OMNI(1'b0)) dut0 (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .freq(freq0), .velocity(vel0), .gate(gate0),
        .note_on_pulse(on0), .note_off_pulse(off0)
    );

    midi_note_decoder #(.CHANNEL(4'd3), .OMNI(1'b1)) dut1 (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .freq(freq1), .velocity(vel1), .gate(gate1),
        .note_on_pulse(on1), .note_off_pulse(off1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; the byte is captured on the following rising edge.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Checks the channel-0 instance right after a message's last byte has been captured.
    task automatic expect0(input string tag, input logic [6:0] f, input logic [6:0] v,
                           input logic g, input logic on, input logic off);
        chk({tag, ".freq"}, 32'(freq0), 32'(f));
        chk({tag, ".vel"},  32'(vel0),  32'(v));
        chk({tag, ".gate"}, 32'(gate0), 32'(g));
        chk({tag, ".on"},   32'(on0),   32'(on));
        chk({tag, ".off"},  32'(off0),  32'(off));
    endtask

    initial begin
        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        expect0("reset", 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
        chk("reset.omni_gate", 32'(gate1), 32'd0);

        // Basic Note On 0x45 (69) -> index 48
        send(8'h90); send(8'h45); send(8'h64);
        expect0("on1", 7'd48, 7'd100, 1'b1, 1'b1, 1'b0);
        chk("on1.omni_freq", 32'(freq1), 32'd48);
        @(negedge clk);
        chk("on1.pulse_width", 32'(on0), 32'd0);

        // Running status
        send(8'h90); send(8'h3C); send(8'h40);
        expect0("rs_a", 7'd39, 7'd64, 1'b1, 1'b1, 1'b0);
        send(8'h40); send(8'h50);
        expect0("rs_b", 7'd43, 7'd80, 1'b1, 1'b1, 1'b0);
        send(8'h3C); send(8'h00);
        expect0("off_nomatch", 7'd43, 7'd80, 1'b1, 1'b0, 1'b0);
        send(8'h40); send(8'h00);
        expect0("off_match", 7'd43, 7'd80, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("off.pulse_width", 32'(off0), 32'd0);

        // Real-time bytes interleaved between status and data
        send(8'h90); send(8'hF8); send(8'h45); send(8'hFE); send(8'h7F);
        expect0("rt", 7'd48, 7'd127, 1'b1, 1'b1, 1'b0);

        // Channel 1: ignored by channel-0 instance, taken by omni instance
        send(8'h91); send(8'h45); send(8'h64);
        expect0("ch1", 7'd48, 7'd127, 1'b1, 1'b0, 1'b0);
        chk("omni.vel", 32'(vel1), 32'd100);
        chk("omni.on",  32'(on1),  32'd1);

        // Out-of-range notes
        send(8'h90); send(8'h14); send(8'h64);
        expect0("low_oor", 7'd48, 7'd127, 1'b1, 1'b0, 1'b0);
        send(8'h6D); send(8'h64);
        expect0("high_oor", 7'd48, 7'd127, 1'b1, 1'b0, 1'b0);

        // Range boundaries: note 21 -> 0, note 108 -> 87
        send(8'h15); send(8'h01);
        expect0("low_edge", 7'd0, 7'd1, 1'b1, 1'b1, 1'b0);
        send(8'h6C); send(8'h02);
        expect0("high_edge", 7'd87, 7'd2, 1'b1, 1'b1, 1'b0);

        // Explicit 0x80 Note Off
        send(8'h80); send(8'h6C); send(8'h00);
        expect0("off80", 7'd87, 7'd2, 1'b0, 1'b0, 1'b1);

        // Program change with running status consumes bytes silently
        send(8'hC0); send(8'h05);
        send(8'h45);
        expect0("pc_a", 7'd87, 7'd2, 1'b0, 1'b0, 1'b0);
        send(8'h64);
        expect0("pc_b", 7'd87, 7'd2, 1'b0, 1'b0, 1'b0);

        // SysEx aborts the note and clears running status
        send(8'h90); send(8'h45); send(8'hF0); send(8'h01); send(8'h02); send(8'hF7);
        send(8'h45); send(8'h64);
        expect0("sysex", 7'd87, 7'd2, 1'b0, 1'b0, 1'b0);
        send(8'h45); send(8'h64);
        expect0("sysex_rs", 7'd87, 7'd2, 1'b0, 1'b0, 1'b0);

        // Gate on again, then reset mid-message
        send(8'h90); send(8'h45); send(8'h64);
        expect0("pre_rst", 7'd48, 7'd100, 1'b1, 1'b1, 1'b0);
        send(8'h45);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        expect0("mid_rst", 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
        send(8'h64);
        expect0("post_rst", 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);

        // rx_data wiggling with rx_valid low is ignored
        rx_data = 8'h90;
        @(negedge clk);
        rx_data = 8'h45;
        @(negedge clk);
        rx_data = 8'h64;
        @(negedge clk);
        expect0("novalid", 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
